// File: rtl/filter_mem_pp_if.sv
// Bus bundle for filter_mem_pp: weight-load channel in, NoC packet channel out.
// Both channels: a beat transfers on a rising edge with valid & ready; valid and payload hold until then.
interface filter_mem_pp_if #(
  parameter int ADDR_W     = 5,
  parameter int WIDTH_DATA = 13,
  parameter int PKT_W      = 32
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [WIDTH_DATA-1:0] wr_data;
  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [PKT_W-1:0]      pkt;
  logic                  dbg_state;

  modport master (
    output wr_valid, wr_addr, wr_data, pkt_ready,
    input  wr_ready, pkt_valid, pkt, dbg_state
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, pkt_ready,
    output wr_ready, pkt_valid, pkt, dbg_state
  );
endinterface

// File: rtl/filter_mem_pp.sv
// Ping-pong filter weight store: one bank loads while the other streams out row by row as NoC packets.
// Optional FMEM_ERR_EN adds the sticky err output for out-of-range writes.
module filter_mem_pp #(
  parameter int          WIDTH_DATA = 13,
  parameter int          DEPTH_F    = 5,
  parameter int          WIDTH_F    = 5,
  parameter logic [7:0]  DST_BASE   = 8'd0,
  parameter logic [1:0]  PKT_TYPE   = 2'b00
) (
  input  logic             clk,
  input  logic             rst,
  filter_mem_pp_if.slave   bus,
  output logic             busy
`ifdef FMEM_ERR_EN
  ,
  output logic             err
`endif
);
  localparam int N      = DEPTH_F * WIDTH_F;
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(N + 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic [1:0]            full_q, full_d;
  logic                  wbank_q, wbank_d;
  logic                  rbank_q, rbank_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;
  logic [7:0]            row_q, row_d;
  logic [7:0]            col_q, col_d;
  logic [ADDR_W-1:0]     raddr_q, raddr_d;
  logic [WIDTH_DATA-1:0] mem_q [2][N];

  logic                  wr_ready, wr_fire, wr_in_range, wr_store, wr_last;
  logic                  send, pkt_fire, last_col, last_row, rd_last;
  logic [WIDTH_DATA-1:0] rd_data;
  logic [7:0]            dst;

  assign wr_ready    = !full_q[wbank_q];
  assign wr_fire     = bus.wr_valid & wr_ready;
  assign wr_in_range = ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(N));
  assign wr_store    = wr_fire & wr_in_range;
  assign wr_last     = wr_store & (wcnt_q == CNT_W'(N - 1));

  assign send     = (state_q == SEND);
  assign pkt_fire = send & bus.pkt_ready;
  assign last_col = (col_q == 8'(WIDTH_F - 1));
  assign last_row = (row_q == 8'(DEPTH_F - 1));
  assign rd_last  = pkt_fire & last_col & last_row;

  // raddr tracks row*WIDTH_F+col so no multiplier sits in the read path.
  assign rd_data = mem_q[rbank_q][raddr_q];
  assign dst     = DST_BASE + row_q;

  assign bus.wr_ready  = wr_ready;
  assign bus.pkt_valid = send;
  assign bus.pkt       = send ? {1'b0, PKT_TYPE, dst, col_q, rd_data} : '0;
  assign bus.dbg_state = send;
  assign busy          = (|full_q) | send;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    raddr_d = raddr_q;
    rbank_d = rbank_q;
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = SEND;
          row_d   = '0;
          col_d   = '0;
          raddr_d = '0;
        end
      end
      SEND: begin
        if (pkt_fire) begin
          raddr_d = raddr_q + ADDR_W'(1);
          if (last_col) begin
            col_d = '0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
          if (last_row && last_col) begin
            state_d = IDLE;
            rbank_d = ~rbank_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Same-edge close of the write bank and drain of the read bank hit different banks.
  always_comb begin
    full_d  = full_q;
    wbank_d = wbank_q;
    wcnt_d  = wcnt_q;
    if (rd_last) full_d[rbank_q] = 1'b0;
    if (wr_store) begin
      if (wr_last) begin
        full_d[wbank_q] = 1'b1;
        wcnt_d          = '0;
        wbank_d         = ~wbank_q;
      end else begin
        wcnt_d = wcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      raddr_q <= raddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_store) mem_q[wbank_q][bus.wr_addr] <= bus.wr_data;
  end

`ifdef FMEM_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (wr_fire && !wr_in_range) err_q <= 1'b1;
  end

  assign err = err_q;

  always @(posedge clk) begin
    if (!rst && wr_fire && !wr_in_range && !err_q)
      $error("filter_mem_pp: out-of-range write addr %0d", bus.wr_addr);
  end
`endif
endmodule

// File: tb/tb_filter_mem_pp.sv
// Directed bench for filter_mem_pp: default 5x5 instance plus a 3x4 instance with wrapping dst.
module tb_filter_mem_pp;
  localparam int W  = 13;
  localparam int N  = 25;
  localparam int AW = 5;
  localparam int PW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic busy, busy2;
`ifdef FMEM_ERR_EN
  logic err, err2;
`endif

  filter_mem_pp_if #(.ADDR_W(AW), .WIDTH_DATA(W), .PKT_W(PW)) bus ();
  filter_mem_pp_if #(.ADDR_W(4), .WIDTH_DATA(W), .PKT_W(PW)) bus2 ();

  filter_mem_pp #(
    .WIDTH_DATA(W), .DEPTH_F(5), .WIDTH_F(5), .DST_BASE(8'h00), .PKT_TYPE(2'b00)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy)
`ifdef FMEM_ERR_EN
    , .err(err)
`endif
  );

  filter_mem_pp #(
    .WIDTH_DATA(W), .DEPTH_F(3), .WIDTH_F(4), .DST_BASE(8'hFE), .PKT_TYPE(2'b00)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .busy(busy2)
`ifdef FMEM_ERR_EN
    , .err(err2)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] rx_q[$];
  logic [PW-1:0] rx2_q[$];
  longint        rise_q[$];
  longint        end_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic [7:0] dst, input logic [7:0] idx, input int data);
    logic [W-1:0] d;
    d = W'(data);
    return {1'b0, 2'b00, dst, idx, d};
  endfunction

  // Load-side reference: bank contents and fill count; a closed bank queues its packets.
  int m_mem [2][N];
  int m_wb  = 0;
  int m_cnt = 0;

  function automatic void model_wr(input int addr, input int data);
    if (addr < N) begin
      m_mem[m_wb][addr] = data;
      m_cnt++;
      if (m_cnt == N) begin
        for (int a = 0; a < N; a++)
          exp_q.push_back(mk_pkt(8'(a / 5), 8'(a % 5), m_mem[m_wb][a]));
        m_cnt = 0;
        m_wb  = 1 - m_wb;
      end
    end
  endfunction

  // ---------------- packet monitor / ready driver ----------------
  int   ready_mode = 0;  // 0: always ready, 1: random 50%
  int   stop_after = -1;
  int   beats      = 0;
  int   bank_beats = 0;
  bit   gap_chk    = 1'b0;
  bit   prev_v     = 1'b0;
  bit   prev_hs    = 1'b0;
  bit   mon_r      = 1'b0;
  logic [PW-1:0] prev_pkt = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_v        = 1'b0;
      prev_hs       = 1'b0;
      gap_chk       = 1'b0;
      bus.pkt_ready = 1'b0;
    end else begin
      if (gap_chk) begin
        check("idle_gap", bus.pkt_valid, 0);
        gap_chk = 1'b0;
      end
      if (prev_v && !prev_hs) begin
        check("pkt_valid_hold", bus.pkt_valid, 1);
        check("pkt_stable", bus.pkt, prev_pkt);
      end
      mon_r = (ready_mode == 1) ? ($urandom_range(0, 1) == 1) : (ready_mode == 0);
      if (stop_after >= 0 && beats >= stop_after) mon_r = 1'b0;
      bus.pkt_ready = mon_r;
      if (bus.pkt_valid && !prev_v) rise_q.push_back($time);
      if (bus.pkt_valid && mon_r) begin
        if (exp_q.size() == 0) check("exp_q_size", exp_q.size(), 1);
        else check("pkt", bus.pkt, exp_q.pop_front());
        rx_q.push_back(bus.pkt);
        beats++;
        bank_beats++;
        if (bank_beats == N) begin
          end_q.push_back($time + 5);
          bank_beats = 0;
          gap_chk    = 1'b1;
        end
      end
      prev_v   = bus.pkt_valid;
      prev_hs  = bus.pkt_valid && mon_r;
      prev_pkt = bus.pkt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    bus.wr_valid  = 1'b0;
    bus2.wr_valid = 1'b0;
    m_wb = 0; m_cnt = 0; bank_beats = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic begin_test();
    rise_q.delete();
    end_q.delete();
    rx_q.delete();
  endtask

  // Called at a negedge; returns the time of the accepting edge.
  task automatic wr_word(input int addr, input int data, output longint t);
    bit rdy;
    int n;
    n = 0;
    rdy = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(addr);
    bus.wr_data  = W'(data);
    while (n < 2000) begin
      rdy = bus.wr_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      @(negedge clk);
    end
    t = $time;
    if (rdy) model_wr(addr, data);
    else check("wr_timeout", n, 0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  longint t, t25;
  int k, n, wcount;

  initial begin
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus2.wr_valid = 1'b0;
    bus2.wr_addr  = '0;
    bus2.wr_data  = '0;
    bus2.pkt_ready = 1'b1;

    // reset state, sampled while rst is held
    @(negedge clk);
    check("rst_wr_ready", bus.wr_ready, 1);
    check("rst_pkt_valid", bus.pkt_valid, 0);
    check("rst_pkt", bus.pkt, 0);
    check("rst_busy", busy, 0);
    check("rst_state", bus.dbg_state, 0);
`ifdef FMEM_ERR_EN
    check("rst_err", err, 0);
`endif
    do_reset();

    // A: sequential 1..25, pkt_ready always high
    begin_test();
    ready_mode = 0;
    for (int i = 0; i < N; i++) wr_word(i, i + 1, t);
    check("a_busy_loaded", busy, 1);
    wait_drain("a_drain");
    check("a_latency", rise_q[0] - t, 15);
    check("a_back_to_back", end_q[0] - rise_q[0], 245);
    check("a_pkt0", rx_q[0], 32'h0000_0001);
    check("a_pkt7", rx_q[7], 32'h0020_4008);
    check("a_pkt24", rx_q[24], 32'h0080_8019);
    check("a_rx_count", rx_q.size(), 25);

    // B: ping-pong under random backpressure, third load stalls
    begin_test();
    ready_mode = 1;
    for (int i = 0; i < N; i++) wr_word(i, 100 + i, t);
    for (int i = 0; i < N; i++) wr_word(i, 200 + i, t);
    check("b_both_full_wr_ready", bus.wr_ready, 0);
    wr_word(0, 300, t);
    check("b_stall_release", t - end_q[0], 10);
    for (int i = 1; i < N; i++) wr_word(i, 300 + i, t);
    wait_drain("b_drain");
    check("b_idle_one_cycle", rise_q[1] - end_q[0], 15);
    check("b_rx_count", rx_q.size(), 75);

    // C: reverse order with addr 3 written twice; bank closes on the 25th write
    begin_test();
    ready_mode = 0;
    wcount = 0;
    t25 = 0;
    for (int a = N - 1; a >= 0; a--) begin
      if (a == 3) begin
        wr_word(3, 7, t);
        wcount++;
        if (wcount == N) t25 = t;
        wr_word(3, 9, t);
      end else begin
        wr_word(a, 40 + a, t);
      end
      wcount++;
      if (wcount == N) t25 = t;
    end
    wait_drain("c_drain");
    check("c_count_close", rise_q[0] - t25, 15);
    check("c_dup_last_wins", rx_q[3], 32'h0000_6009);
    check("c_rx_count", rx_q.size(), 25);
    do_reset();

    // D: out-of-range write is accepted, dropped and not counted
    begin_test();
    wr_word(30, 5, t);
`ifdef FMEM_ERR_EN
    check("d_err", err, 1);
`endif
    check("d_busy_after_oor", busy, 0);
    for (int i = 0; i < N; i++) wr_word(i, 700 + i, t);
    wait_drain("d_drain");
    check("d_count_close", rise_q[0] - t, 15);
    check("d_rx_count", rx_q.size(), 25);

    // E: reset after 10 beats, then a fresh load restarts at row 0 col 0
    begin_test();
    beats = 0;
    stop_after = 10;
    for (int i = 0; i < N; i++) wr_word(i, 500 + i, t);
    n = 0;
    while (beats < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("e_beats", beats, 10);
    @(negedge clk);
    check("e_pre_rst_valid", bus.pkt_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("e_rst_pkt_valid", bus.pkt_valid, 0);
    check("e_rst_pkt", bus.pkt, 0);
    check("e_rst_busy", busy, 0);
    check("e_rst_wr_ready", bus.wr_ready, 1);
    exp_q.delete();
    m_wb = 0; m_cnt = 0; bank_beats = 0;
    stop_after = -1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    begin_test();
    for (int i = 0; i < N; i++) wr_word(i, 600 + i, t);
    wait_drain("e_drain");
    check("e_first_pkt", rx_q[0], 32'h0000_0258);
    check("e_rx_count", rx_q.size(), 25);

    // F: 3x4 instance, DST_BASE=FE wraps to 00
    for (int i = 0; i < 12; i++) begin
      check("f_wr_ready", bus2.wr_ready, 1);
      bus2.wr_valid = 1'b1;
      bus2.wr_addr  = 4'(i);
      bus2.wr_data  = W'(100 + i);
      @(posedge clk);
      @(negedge clk);
    end
    bus2.wr_valid = 1'b0;
    k = 0;
    n = 0;
    while (k < 12 && n < 100) begin
      if (bus2.pkt_valid) begin
        check("f_pkt", bus2.pkt, mk_pkt(8'hFE + 8'(k / 4), 8'(k % 4), 100 + k));
        rx2_q.push_back(bus2.pkt);
        k++;
      end
      @(negedge clk);
      n++;
    end
    check("f_pkt_count", k, 12);
    check("f_pkt0", rx2_q[0], 32'h1FC0_0064);
    check("f_pkt4", rx2_q[4], 32'h1FE0_0068);
    check("f_pkt8", rx2_q[8], 32'h0000_006C);
    check("f_idle_valid", bus2.pkt_valid, 0);
    check("f_idle_busy", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
